// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
// Turns the CPU's request/response instruction and data ports into a single
// AXI3 master. One read and one write may be outstanding at a time, and every
// transfer is a single beat.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   inst_*               instruction fetch port (reads only, always word size)
//   data_*               data port (loads and stores, byte/half/word)
//   ar*/r*               AXI read address and read data channels
//   aw*/w*/b*            AXI write address, write data and write response channels
//
// Data requests win over fetches. A load is held off while a store is in
// flight, and a store is held off while a load is in flight. Fetches may run
// alongside a store.
module cpu_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // instruction port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response channel
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} w_state_t;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Byte-lane strobes for a store of the given size at the given address offset.
    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << lo;
            2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    r_state_t    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [1:0]  r_size_q, r_size_d;
    logic        r_src_q, r_src_d;

    w_state_t    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [1:0]  w_size_q, w_size_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        rd_data_acc_s;
    logic        rd_inst_acc_s;
    logic        wr_acc_s;
    logic        aw_fin_s;
    logic        w_fin_s;
    logic        rid_unused_s;

    // Only one read is ever outstanding, so the returned ID carries no information.
    assign rid_unused_s = ^rid;

    // State and capture registers for both channels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_size_q  <= 2'd0;
            r_src_q   <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_size_q  <= 2'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_src_q   <= r_src_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Read FSM: request arbitration (data before inst) and AR/R sequencing.
    always_comb begin
        r_state_d     = r_state_q;
        r_addr_d      = r_addr_q;
        r_size_d      = r_size_q;
        r_src_d       = r_src_q;
        rd_data_acc_s = 1'b0;
        rd_inst_acc_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                // A load waits for any store to finish so it cannot overtake it.
                if (data_req && !data_wr && (w_state_q == W_IDLE)) begin
                    rd_data_acc_s = 1'b1;
                    r_addr_d      = data_addr;
                    r_size_d      = data_size;
                    r_src_d       = SRC_DATA;
                    r_state_d     = R_AR;
                end else if (inst_req) begin
                    rd_inst_acc_s = 1'b1;
                    r_addr_d      = inst_addr;
                    r_size_d      = 2'd2;
                    r_src_d       = SRC_INST;
                    r_state_d     = R_AR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_state_d = R_R;
                end else begin
                    r_state_d = R_AR;
                end
            end
            R_R: begin
                if (rvalid) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_R;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W complete independently; each flag latches its own handshake.
    assign aw_fin_s = aw_done_q | awready;
    assign w_fin_s  = w_done_q | wready;

    // Write FSM: store acceptance, AW/W issue and B collection.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_acc_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // A store may start while the read side is idle or busy with a fetch.
                if (data_req && data_wr && ((r_state_q == R_IDLE) || (r_src_q == SRC_INST))) begin
                    wr_acc_s  = 1'b1;
                    w_addr_d  = data_addr;
                    w_size_d  = data_size;
                    w_data_d  = data_wdata;
                    w_strb_d  = strb_of(data_size, data_addr[1:0]);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_REQ;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_REQ: begin
                if (aw_fin_s && w_fin_s) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_B;
                end else begin
                    aw_done_d = aw_fin_s;
                    w_done_d  = w_fin_s;
                    w_state_d = W_REQ;
                end
            end
            W_B: begin
                if (bvalid) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_B;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Acceptance is combinational, so it is masked while reset is asserted.
    assign inst_addr_ok = rd_inst_acc_s & resetn;
    assign data_addr_ok = (rd_data_acc_s | wr_acc_s) & resetn;

    assign inst_data_ok = (r_state_q == R_R) && rvalid && (r_src_q == SRC_INST);
    assign data_data_ok = ((r_state_q == R_R) && rvalid && (r_src_q == SRC_DATA)) ||
                          ((w_state_q == W_B) && bvalid);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = {3'b000, r_src_q};
    assign araddr  = r_addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, r_size_q};
    assign arburst = 2'd1;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_R);

    assign awid    = 4'd1;
    assign awaddr  = w_addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, w_size_q};
    assign awburst = 2'd1;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (w_state_q == W_REQ) && !aw_done_q;

    assign wid     = 4'd1;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (w_state_q == W_REQ) && !w_done_q;

    assign bready  = (w_state_q == W_B);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: a CPU request model and an AXI slave model drive
// the bridge, and a transaction-level model predicts every handshake and
// every response cycle.
module tb_cpu_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0) return 4'b0001 << lo;
        if (sz == 2'd1) return 4'b0011 << {lo[1], 1'b0};
        return 4'b1111;
    endfunction

    // slave memory (word index = addr[5:2])
    logic [31:0] mem [16];

    // outstanding read: 0 none, 1 awaiting AR, 2 awaiting R
    int          r_ph = 0;
    logic        r_src = 1'b0;
    logic [31:0] r_addr = 32'd0;
    logic [1:0]  r_sz = 2'd0;
    int          r_cnt = 0;
    // outstanding write: 0 none, 1 awaiting AW/W, 2 awaiting B
    int          w_ph = 0;
    logic        w_awd = 1'b0, w_wd = 1'b0;
    logic [31:0] w_addr = 32'd0, w_dat = 32'd0;
    logic [1:0]  w_sz = 2'd0;
    int          w_cnt = 0;

    // CPU-side pending requests (held until accepted)
    logic        c_ireq = 1'b0, c_dreq = 1'b0, c_dwr = 1'b0;
    logic [31:0] c_iaddr = 32'd0, c_daddr = 32'd0, c_dwdata = 32'd0;
    logic [1:0]  c_dsz = 2'd0;

    // slave policy
    logic p_ar = 1'b1, p_aw = 1'b1, p_w = 1'b1;
    int   r_fixed = 0, b_fixed = 0;

    int cyc = 0;
    int iacc_cyc = 0, dacc_cyc = 0, iok_cyc = 0, drok_cyc = 0, wok_cyc = 0;
    int n_iok = 0, n_wok = 0, n0 = 0;
    logic [31:0] last_irdata = 32'd0, last_drdata = 32'd0;

    function automatic int pick(input int fixed);
        if (fixed >= 0) return fixed;
        return int'($urandom_range(3, 0));
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle();
        logic exp_drd, exp_dwr, exp_iacc, ex_iok, ex_dok;
        logic [3:0] es;
        inst_req   = c_ireq;
        inst_addr  = c_iaddr;
        data_req   = c_dreq;
        data_wr    = c_dwr;
        data_size  = c_dsz;
        data_addr  = c_daddr;
        data_wdata = c_dwdata;
        arready    = p_ar;
        awready    = p_aw;
        wready     = p_w;
        rvalid     = (r_ph == 2) && (r_cnt == 0);
        rid        = {3'b000, r_src};
        rdata      = rvalid ? mem[r_addr[5:2]] : $urandom;
        bvalid     = (w_ph == 2) && (w_cnt == 0);
        #4;
        exp_drd  = c_dreq && !c_dwr && (r_ph == 0) && (w_ph == 0);
        exp_iacc = c_ireq && (r_ph == 0) && !exp_drd;
        exp_dwr  = c_dreq && c_dwr && (w_ph == 0) && ((r_ph == 0) || (r_src == 1'b0));
        ex_iok   = rvalid && (r_src == 1'b0);
        ex_dok   = (rvalid && r_src) || bvalid;
        check_eq("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, exp_iacc});
        check_eq("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, exp_drd || exp_dwr});
        check_eq("arvalid", {31'd0, arvalid}, {31'd0, r_ph == 1});
        check_eq("rready", {31'd0, rready}, {31'd0, r_ph == 2});
        check_eq("awvalid", {31'd0, awvalid}, {31'd0, (w_ph == 1) && !w_awd});
        check_eq("wvalid", {31'd0, wvalid}, {31'd0, (w_ph == 1) && !w_wd});
        check_eq("bready", {31'd0, bready}, {31'd0, w_ph == 2});
        check_eq("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, ex_iok});
        check_eq("data_data_ok", {31'd0, data_data_ok}, {31'd0, ex_dok});
        if (ex_iok) begin
            check_eq("inst_rdata", inst_rdata, rdata);
            iok_cyc = cyc; n_iok++; last_irdata = inst_rdata;
        end
        if (rvalid && r_src) begin
            check_eq("data_rdata", data_rdata, rdata);
            drok_cyc = cyc; last_drdata = data_rdata;
        end
        if (bvalid) begin
            wok_cyc = cyc; n_wok++;
        end
        // read channel progress
        if ((r_ph == 1) && p_ar) begin
            check_eq("araddr", araddr, r_addr);
            check_eq("arsize", {29'd0, arsize}, {29'd0, 1'b0, r_sz});
            check_eq("arid", {28'd0, arid}, {28'd0, 3'b000, r_src});
            r_ph = 2; r_cnt = pick(r_fixed);
        end else if (r_ph == 2) begin
            if (rvalid) r_ph = 0; else r_cnt--;
        end
        // write channel progress
        if (w_ph == 1) begin
            if (!w_awd && p_aw) begin
                check_eq("awaddr", awaddr, w_addr);
                check_eq("awsize", {29'd0, awsize}, {29'd0, 1'b0, w_sz});
                w_awd = 1'b1;
            end
            if (!w_wd && p_w) begin
                es = exp_strb(w_sz, w_addr[1:0]);
                check_eq("wdata", wdata, w_dat);
                check_eq("wstrb", {28'd0, wstrb}, {28'd0, es});
                for (int b = 0; b < 4; b++)
                    if (es[b]) mem[w_addr[5:2]][8*b +: 8] = w_dat[8*b +: 8];
                w_wd = 1'b1;
            end
            if (w_awd && w_wd) begin
                w_ph = 2; w_cnt = pick(b_fixed);
            end
        end else if (w_ph == 2) begin
            if (bvalid) w_ph = 0; else w_cnt--;
        end
        // new acceptances
        if (exp_drd) begin
            r_ph = 1; r_src = 1'b1; r_addr = c_daddr; r_sz = c_dsz; c_dreq = 1'b0; dacc_cyc = cyc;
        end else if (exp_iacc) begin
            r_ph = 1; r_src = 1'b0; r_addr = c_iaddr; r_sz = 2'd2; c_ireq = 1'b0; iacc_cyc = cyc;
        end
        if (exp_dwr) begin
            w_ph = 1; w_awd = 1'b0; w_wd = 1'b0; w_addr = c_daddr; w_sz = c_dsz;
            w_dat = c_dwdata; c_dreq = 1'b0; dacc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000; data_wdata = 32'd0;
        arready = 1'b1; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        #1 resetn = 1'b0;
        #2;
        // reset state, with requests already pending at the inputs
        check_eq("rst_valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
        check_eq("rst_readys", {30'd0, rready, bready}, 32'd0);
        check_eq("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check_eq("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("axlen", {24'd0, arlen, awlen}, 32'd0);
        check_eq("axburst", {28'd0, arburst, awburst}, 32'h5);
        check_eq("axmisc", {12'd0, arlock, awlock, arcache, awcache, arprot, awprot}, 32'd0);
        check_eq("wid_wlast", {23'd0, awid, wid, wlast}, {23'd0, 4'd1, 4'd1, 1'b1});
        @(posedge clk);
        #1 resetn = 1'b1;

        // instruction fetch, zero-wait slave
        mem[0] = 32'h3C1D_BFC0;
        p_ar = 1'b1; p_aw = 1'b1; p_w = 1'b1; r_fixed = 0; b_fixed = 0;
        c_ireq = 1'b1; c_iaddr = 32'hBFC0_0000; n0 = n_iok;
        repeat (5) cycle();
        check_eq("fetch_done", n_iok - n0, 32'd1);
        check_eq("fetch_latency", iok_cyc - iacc_cyc, 32'd2);
        check_eq("fetch_rdata", last_irdata, 32'h3C1D_BFC0);

        // data beats inst in the same cycle; inst accepted right after R
        c_ireq = 1'b1; c_iaddr = 32'hBFC0_0004;
        c_dreq = 1'b1; c_dwr = 1'b0; c_dsz = 2'd2; c_daddr = 32'h0000_1000;
        repeat (7) cycle();
        check_eq("prio_inst_after_r", iacc_cyc - drok_cyc, 32'd1);

        // byte store, AW ready three cycles before W
        c_dreq = 1'b1; c_dwr = 1'b1; c_dsz = 2'd0; c_daddr = 32'h0000_1003; c_dwdata = 32'hAB00_0000;
        p_aw = 1'b1; p_w = 1'b0; n0 = n_wok;
        repeat (4) cycle();
        p_w = 1'b1;
        repeat (4) cycle();
        check_eq("store_once", n_wok - n0, 32'd1);

        // load behind a slow store, with a fetch in between
        c_dreq = 1'b1; c_dwr = 1'b1; c_dsz = 2'd2; c_daddr = 32'h0000_1010; c_dwdata = 32'h1234_5678;
        b_fixed = 5;
        cycle();
        c_dreq = 1'b1; c_dwr = 1'b0; c_dsz = 2'd2; c_daddr = 32'h0000_1010;
        c_ireq = 1'b1; c_iaddr = 32'hBFC0_000C; n0 = n_iok;
        repeat (14) cycle();
        check_eq("load_after_store", dacc_cyc - wok_cyc, 32'd1);
        check_eq("fetch_during_store", n_iok - n0, 32'd1);
        check_eq("load_sees_store", last_drdata, 32'h1234_5678);
        b_fixed = 0;

        // reset while arvalid is up
        p_ar = 1'b0; c_ireq = 1'b1; c_iaddr = 32'hBFC0_0010;
        repeat (2) cycle();
        check_eq("pre_rst_arvalid", {31'd0, arvalid}, 32'd1);
        inst_req = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check_eq("async_rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_eq("async_rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        r_ph = 0; w_ph = 0; c_ireq = 1'b0; c_dreq = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        p_ar = 1'b1; c_ireq = 1'b1; c_iaddr = 32'hBFC0_0014; n0 = n_iok;
        repeat (5) cycle();
        check_eq("post_rst_fetch", n_iok - n0, 32'd1);
        check_eq("post_rst_latency", iok_cyc - iacc_cyc, 32'd2);

        // randomized traffic
        r_fixed = -1; b_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!c_ireq && ($urandom_range(3, 0) == 0)) begin
                c_ireq  = 1'b1;
                c_iaddr = 32'hBFC0_0000 + 32'($urandom_range(15, 0)) * 32'd4;
            end
            if (!c_dreq && ($urandom_range(2, 0) == 0)) begin
                c_dreq   = 1'b1;
                c_dwr    = 1'($urandom_range(1, 0));
                c_dsz    = 2'($urandom_range(2, 0));
                c_daddr  = 32'h0000_1000 + 32'($urandom_range(63, 0));
                c_dwdata = $urandom;
            end
            p_ar = 1'($urandom_range(1, 0));
            p_aw = 1'($urandom_range(1, 0));
            p_w  = 1'($urandom_range(1, 0));
            cycle();
        end
        p_ar = 1'b1; p_aw = 1'b1; p_w = 1'b1;
        repeat (30) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of mycpu_top.
- Converts the CPU's request/response instruction and data memory ports into one AXI3 master port for the AXI_CPU SoC.
- Supports one outstanding read and one outstanding write at a time, with single-beat transfers only.
- Data requests take priority over instruction fetches, and read/write ordering is preserved on the data side.

Parameters:
- none (AXI ID, burst and length fields are fixed)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
inst_req  in  1  instruction read request (reads only)
inst_addr  in  32  fetch byte address; size is always word
inst_addr_ok  out  1  request accepted this cycle (combinational)
inst_data_ok  out  1  inst_rdata valid this cycle
inst_rdata  out  32  fetched word
data_req  in  1  data request
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  byte address
data_wdata  in  32  store data, already lane-aligned
data_addr_ok  out  1  request accepted this cycle (combinational)
data_data_ok  out  1  load data valid, or store complete
data_rdata  out  32  load word
arid  out  4  0 = inst, 1 = data
araddr/arsize  out  32/3  read address, size
arvalid/arready  out/in  1/1  AR handshake
rid/rdata  in  4/32  read id, data
rvalid/rready  in/out  1/1  R handshake
awaddr/awsize  out  32/3  write address, size
awvalid/awready  out/in  1/1  AW handshake
wdata/wstrb  out  32/4  write data, byte strobes
wvalid/wready  out/in  1/1  W handshake
bvalid/bready  in/out  1/1  B handshake

Constant outputs, standard AXI3 widths:
- arlen = awlen = 0; arburst = awburst = 1.
- lock, cache and prot fields = 0.
- awid = wid = 1; wlast = 1.

Behaviour:
- Reset (async, resetn = 0): both FSMs go to IDLE. arvalid, awvalid, wvalid, rready, bready, all addr_ok and all data_ok outputs = 0. Captured address, size and source registers clear to 0.
- Read FSM states: R_IDLE -> R_AR -> R_R -> R_IDLE.
- In R_IDLE, data-read acceptance: data_req & ~data_wr & write FSM in W_IDLE.
  - data_addr_ok = 1; capture addr, size and src = data.
  - Otherwise, if inst_req: inst_addr_ok = 1; capture with size 2 and src = inst.
  - Either case moves to R_AR next cycle.
  - Data has priority over inst; at most one addr_ok is asserted per cycle.
- R_AR: arvalid = 1 with araddr and arsize = {0, size} held stable; on arready go to R_R.
- R_R: rready = 1. On rvalid, {src}_data_ok = 1 for exactly that cycle and {src}_rdata = rdata (combinational passthrough), then go to R_IDLE. rid is ignored (single outstanding read).
- Write FSM states: W_IDLE -> W_REQ -> W_B -> W_IDLE.
- In W_IDLE, data-write acceptance: data_req & data_wr & the read FSM is not holding a data read (R_IDLE, or src = inst).
  - data_addr_ok = 1; capture addr, size, wdata and strobe; go to W_REQ.
- W_REQ: awvalid and wvalid are both asserted and deassert independently on their own handshake (aw_done / w_done flags). When both are done (they may complete in the same cycle), go to W_B.
- W_B: bready = 1. On bvalid, data_data_ok = 1 for one cycle, then go to W_IDLE. bresp is ignored.
- wstrb derivation:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: addr[1] ? 4'b1100 : 4'b0011
  - size 2: 4'b1111
- The hazard rules make read and write data_data_ok mutually exclusive, and no load can bypass an in-flight store.
- Inst fetches may overlap with an in-flight store.
- Minimum read latency: accept in cycle T, AR handshake in T+1, data_ok in T+2 with a zero-wait slave.
- Addresses pass through unmodified; no alignment checking.

Test Plan:
- Inst fetch: inst_req with addr 0xBFC00000, arready and rvalid at first opportunity, rdata 0x3C1DBFC0 -> arid 0, arsize 2; inst_data_ok for one cycle at T+2 with inst_rdata 0x3C1DBFC0.
- Priority: inst_req and data load (addr 0x1000, size 2) asserted in the same cycle -> data_addr_ok = 1 and inst_addr_ok = 0; first AR has arid 1, addr 0x1000; the inst request is accepted only after R returns.
- Byte store: data_wr = 1, size 0, addr 0x1003, wdata 0xAB000000 -> wstrb 4'b1000, awsize 0. AW ready 3 cycles before W ready -> single B handshake, then data_data_ok once.
- Load behind store: store in flight (bvalid withheld 5 cycles) plus a data load request -> data_addr_ok stays 0 until the cycle after data_data_ok for the store. An inst fetch issued meanwhile completes normally.
- Reset mid-transaction: resetn driven low while in R_AR with arvalid = 1 -> arvalid drops asynchronously; after release, a new inst fetch completes normally.
